// File: rtl/mod_counter.sv
// Parametrised modulo up/down counter with IDLE/RUN/DONE run control, sync load and terminal strobe.
// Optional MOD_COUNTER_PINGPONG_EN: free-run reverses direction at the terminals instead of wrapping.
module mod_counter #(
  parameter int WIDTH   = 3,
  parameter int MAX     = (1 << WIDTH) - 1,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             oneshot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic             dir_q
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RSTV = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic             oneshot_q;
  logic [WIDTH-1:0] step_val, load_clamp;
  logic             step_tc, step_done, step_dir;
  logic             do_step, do_start;

  assign load_clamp = (load_val > MAXV) ? MAXV : load_val;
  assign do_start   = start && !stop && (state != RUN);
  assign do_step    = en && !stop && !load && (state == RUN);

  // Result of one enabled step from the current count and active direction.
  always_comb begin
    step_val  = count;
    step_tc   = 1'b0;
    step_done = 1'b0;
    step_dir  = dir_q;
    if (dir_q) begin
      if (count == MAXV) begin
        step_tc = 1'b1;
        if (oneshot_q) begin
          step_val  = MAXV;
          step_done = 1'b1;
        end else begin
`ifdef MOD_COUNTER_PINGPONG_EN
          if (MAXV != ZERO) begin
            step_val = MAXV - ONE;
            step_dir = 1'b0;
            step_tc  = (MAXV - ONE) == ZERO;
          end
`else
          step_val = ZERO;
`endif
        end
      end else begin
        step_val = count + ONE;
`ifdef MOD_COUNTER_PINGPONG_EN
        step_tc  = !oneshot_q && ((count + ONE) == MAXV);
`endif
      end
    end else begin
      if (count == ZERO) begin
        step_tc = 1'b1;
        if (oneshot_q) begin
          step_val  = ZERO;
          step_done = 1'b1;
        end else begin
`ifdef MOD_COUNTER_PINGPONG_EN
          if (MAXV != ZERO) begin
            step_val = ONE;
            step_dir = 1'b1;
            step_tc  = ONE == MAXV;
          end
`else
          step_val = MAXV;
`endif
        end
      end else begin
        step_val = count - ONE;
`ifdef MOD_COUNTER_PINGPONG_EN
        step_tc  = !oneshot_q && ((count - ONE) == ZERO);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Load freezes the state; stop also blocks a start from IDLE/DONE.
  always_comb begin
    state_nxt = state;
    if (!load) begin
      case (state)
        IDLE:    if (do_start) state_nxt = RUN;
        RUN:     if (stop) state_nxt = IDLE;
                 else if (en && step_done) state_nxt = DONE;
        DONE:    if (do_start) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= RSTV;
      tc        <= 1'b0;
      dir_q     <= 1'b1;
      oneshot_q <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        count <= load_clamp;
      end else if (do_start) begin
        dir_q     <= dir;
        oneshot_q <= oneshot;
        if (state == DONE) count <= dir ? ZERO : MAXV;
      end else if (do_step) begin
        count <= step_val;
        tc    <= step_tc;
        dir_q <= step_dir;
      end
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: vector table on a MAX=5 instance, hand sequences for MAX=7 and MAX=0.
module tb_mod_counter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, start, stop, dir, oneshot, load;
  logic [2:0] load_val;
  logic [1:0] lv0;

  logic [2:0] c5, c7;
  logic [1:0] c0;
  logic tc5, b5, d5, q5, tc7, b7, d7, q7, tc0, b0, d0, q0;

  assign lv0 = load_val[1:0];

  mod_counter #(.WIDTH(3), .MAX(5), .RST_VAL(0)) u5 (
    .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop), .dir(dir), .oneshot(oneshot),
    .load(load), .load_val(load_val), .count(c5), .tc(tc5), .busy(b5), .done(d5), .dir_q(q5));
  mod_counter #(.WIDTH(3), .MAX(7), .RST_VAL(0)) u7 (
    .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop), .dir(dir), .oneshot(oneshot),
    .load(load), .load_val(load_val), .count(c7), .tc(tc7), .busy(b7), .done(d7), .dir_q(q7));
  mod_counter #(.WIDTH(2), .MAX(0), .RST_VAL(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop), .dir(dir), .oneshot(oneshot),
    .load(load), .load_val(lv0), .count(c0), .tc(tc0), .busy(b0), .done(d0), .dir_q(q0));

  typedef struct packed {
    logic rst, en, start, stop, dir, oneshot, load;
    logic [2:0] lv;
    logic [2:0] c;
    logic tc, busy, done, dq;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  function automatic vec_t r(logic rs, logic e, logic st, logic sp, logic d, logic os, logic ld,
                             logic [2:0] lv, logic [2:0] c, logic t, logic b, logic dn, logic q);
    vec_t v;
    v = '{rst: rs, en: e, start: st, stop: sp, dir: d, oneshot: os, load: ld, lv: lv,
          c: c, tc: t, busy: b, done: dn, dq: q};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rs, input logic e, input logic st, input logic sp,
                       input logic d, input logic os, input logic ld, input logic [2:0] lv);
    rst = rs; en = e; start = st; stop = sp; dir = d; oneshot = os; load = ld; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);

    //         rst en st sp dr os ld lv   cnt tc bsy dn dq
    vecs.push_back(r(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1)); // reset
    vecs.push_back(r(0, 0, 0, 0, 0, 0, 1, 2,   2, 0, 0, 0, 1)); // load in IDLE
    vecs.push_back(r(0, 0, 1, 0, 0, 1, 0, 0,   2, 0, 1, 0, 0)); // start down one-shot, no step
    vecs.push_back(r(0, 1, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0));
    vecs.push_back(r(0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0));
    vecs.push_back(r(0, 1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1, 0)); // terminal -> DONE
    vecs.push_back(r(0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0)); // held in DONE
    vecs.push_back(r(0, 0, 1, 0, 1, 0, 0, 0,   0, 0, 1, 0, 1)); // restart up free-run
    vecs.push_back(r(0, 1, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 1));
    vecs.push_back(r(0, 1, 0, 0, 0, 0, 0, 0,   2, 0, 1, 0, 1));
    vecs.push_back(r(0, 1, 0, 0, 0, 0, 0, 0,   3, 0, 1, 0, 1));
    vecs.push_back(r(0, 1, 0, 0, 0, 0, 1, 6,   5, 0, 1, 0, 1)); // load clamps, no step
    vecs.push_back(r(0, 1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 1)); // wrap
    vecs.push_back(r(0, 0, 0, 0, 0, 0, 1, 5,   5, 0, 1, 0, 1));
    vecs.push_back(r(0, 1, 0, 1, 0, 0, 0, 0,   5, 0, 0, 0, 1)); // stop beats terminal step
    vecs.push_back(r(0, 1, 0, 0, 0, 0, 0, 0,   5, 0, 0, 0, 1)); // en ignored in IDLE
    vecs.push_back(r(0, 0, 1, 0, 0, 0, 0, 0,   5, 0, 1, 0, 0)); // start from IDLE keeps count
    vecs.push_back(r(0, 1, 0, 0, 0, 0, 0, 0,   4, 0, 1, 0, 0));
    vecs.push_back(r(0, 1, 1, 0, 1, 0, 0, 0,   3, 0, 1, 0, 0)); // start in RUN ignored
    vecs.push_back(r(0, 1, 0, 0, 0, 0, 0, 0,   2, 0, 1, 0, 0));
    vecs.push_back(r(0, 1, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0));
    vecs.push_back(r(0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0));
    vecs.push_back(r(0, 1, 0, 0, 0, 0, 0, 0,   5, 1, 1, 0, 0)); // down wrap to MAX
    vecs.push_back(r(1, 1, 1, 0, 0, 1, 1, 3,   0, 0, 0, 0, 1)); // rst mid-RUN overrides all
    vecs.push_back(r(0, 0, 1, 1, 1, 0, 0, 0,   0, 0, 0, 0, 1)); // stop blocks start

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].start, vecs[i].stop, vecs[i].dir,
            vecs[i].oneshot, vecs[i].load, vecs[i].lv);
      chk($sformatf("v%0d.count", i), 32'(c5),  32'(vecs[i].c));
      chk($sformatf("v%0d.tc", i),    32'(tc5), 32'(vecs[i].tc));
      chk($sformatf("v%0d.busy", i),  32'(b5),  32'(vecs[i].busy));
      chk($sformatf("v%0d.done", i),  32'(d5),  32'(vecs[i].done));
      chk($sformatf("v%0d.dir_q", i), 32'(q5),  32'(vecs[i].dq));
    end

    // MAX=7 full free-run up cycle: 0..7 then wrap to 0 with a single tc.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 1, 0, 0, 0);
    chk("m7.start_count", 32'(c7), 0);
    chk("m7.start_busy", 32'(b7), 1);
    for (int i = 1; i <= 8; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      chk($sformatf("m7.step%0d.count", i), 32'(c7), 32'(i % 8));
      chk($sformatf("m7.step%0d.tc", i), 32'(tc7), (i == 8) ? 1 : 0);
    end

    // MAX=0: free-run pulses tc every enabled step; one-shot finishes at once.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      chk($sformatf("m0.free%0d.count", i), 32'(c0), 0);
      chk($sformatf("m0.free%0d.tc", i), 32'(tc0), 1);
      chk($sformatf("m0.free%0d.busy", i), 32'(b0), 1);
    end
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    chk("m0.os.count", 32'(c0), 0);
    chk("m0.os.tc", 32'(tc0), 1);
    chk("m0.os.done", 32'(d0), 1);
    chk("m0.os.busy", 32'(b0), 0);
    drive(0, 0, 0, 0, 0, 0, 1, 3);
    chk("m0.load_clamp", 32'(c0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
